debug_panel: RTL and testbench

DEBUG_PANEL -- requirements
Module: debug_panel

---
 rtl/debug_panel.sv | 204 ++++++++++++++++++++
 tb/tb_debug_panel.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/debug_panel.sv
// Debug panel: synchronised, debounced step/page keys, manual or free-run CPU stepping,
// and a paged, registered 7-segment hex view of a debug word.
module debug_panel #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DEBOUNCE_CYC = 50000,
  parameter int unsigned RUN_DIV      = 25000000,
  localparam int unsigned PAGES       = DATA_W / (4 * NUM_DIGITS),
  localparam int unsigned PW          = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_step_n,
  input  logic                    key_page_n,
  input  logic                    sw_run,
  input  logic [DATA_W-1:0]       debug_value,
  output logic                    cpu_step,
  output logic [7*NUM_DIGITS-1:0] hex_n,
  output logic [PW-1:0]           page_idx,
  output logic                    step_led
);

  localparam int unsigned CW       = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned DW       = $clog2(RUN_DIV);
  localparam int unsigned PageBits = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CntMax  = CW'(DEBOUNCE_CYC);
  localparam logic [DW-1:0] DivMax  = DW'(RUN_DIV - 1);
  localparam logic [PW-1:0] PageMax = PW'(PAGES - 1);

  typedef enum logic [1:0] {StIdle, StPress, StHeld, StRelease} db_state_e;

  // Bit 0 = step key, bit 1 = page key, bit 2 = run switch.
  logic [2:0] sync1_q, sync2_q;
  logic       run_prev_q;

  db_state_e     db_state_q [2];
  db_state_e     db_state_d [2];
  logic [CW-1:0] db_cnt_q [2];
  logic [CW-1:0] db_cnt_d [2];
  logic [1:0]    acc_d, acc_q;

  logic [DW-1:0]           div_d, div_q;
  logic [PW-1:0]           page_d, page_q;
  logic                    led_d, led_q;
  logic [7*NUM_DIGITS-1:0] hex_d, hex_q;
  logic [PageBits-1:0]     page_nib;
  logic                    run_sync, run_chg, div_hit;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    unique case (nib)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  // Two-flop synchronisers; keys reset released, run switch resets to manual.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 3'b011;
      sync2_q    <= 3'b011;
      run_prev_q <= 1'b0;
    end else begin
      sync1_q    <= {sw_run, key_page_n, key_step_n};
      sync2_q    <= sync1_q;
      run_prev_q <= sync2_q[2];
    end
  end

  // Debounce FSM state register for both keys, plus the registered accept pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        db_state_q[k] <= StIdle;
        db_cnt_q[k]   <= '0;
      end
      acc_q <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        db_state_q[k] <= db_state_d[k];
        db_cnt_q[k]   <= db_cnt_d[k];
      end
      acc_q <= acc_d;
    end
  end

  // Debounce next-state; entering HELD keeps count at max for one cycle to flag the accept.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      db_state_d[k] = db_state_q[k];
      db_cnt_d[k]   = db_cnt_q[k];
      unique case (db_state_q[k])
        StIdle: begin
          if (!sync2_q[k]) begin
            db_state_d[k] = StPress;
            db_cnt_d[k]   = CW'(1);
          end else begin
            db_cnt_d[k] = '0;
          end
        end
        StPress: begin
          if (sync2_q[k]) begin
            db_state_d[k] = StIdle;
            db_cnt_d[k]   = '0;
          end else if (db_cnt_q[k] == CntMax) begin
            db_state_d[k] = StHeld;
          end else begin
            db_cnt_d[k] = db_cnt_q[k] + CW'(1);
          end
        end
        StHeld: begin
          if (sync2_q[k]) begin
            db_state_d[k] = StRelease;
            db_cnt_d[k]   = CW'(1);
          end else begin
            db_cnt_d[k] = '0;
          end
        end
        StRelease: begin
          if (!sync2_q[k]) begin
            db_state_d[k] = StHeld;
            db_cnt_d[k]   = '0;
          end else if (db_cnt_q[k] >= CntMax - CW'(1)) begin
            db_state_d[k] = StIdle;
            db_cnt_d[k]   = '0;
          end else begin
            db_cnt_d[k] = db_cnt_q[k] + CW'(1);
          end
        end
        default: begin
          db_state_d[k] = StIdle;
          db_cnt_d[k]   = '0;
        end
      endcase
    end
  end

  // Debounce output: accept is raised only in the first cycle spent in HELD.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      acc_d[k] = (db_state_q[k] == StHeld) && (db_cnt_q[k] == CntMax);
    end
  end

  // Step source selection, run divider, LED toggle and page advance.
  always_comb begin
    run_sync = sync2_q[2];
    run_chg  = run_sync ^ run_prev_q;
    div_hit  = (div_q == DivMax);
    cpu_step = !run_chg && (run_sync ? div_hit : acc_q[0]);
    if (run_chg || !run_sync || div_hit) begin
      div_d = '0;
    end else begin
      div_d = div_q + DW'(1);
    end
    led_d  = led_q ^ cpu_step;
    page_d = page_q;
    if (acc_q[1] && (PAGES > 1)) begin
      page_d = (page_q == PageMax) ? '0 : page_q + PW'(1);
    end
  end

  // Glyph lookup for the currently selected page.
  always_comb begin
    page_nib = debug_value[page_q * PageBits +: PageBits];
    hex_d    = '1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      hex_d[7*i +: 7] = ~hex_glyph(page_nib[4*i +: 4]);
    end
  end

  // Panel state registers; hex_n resets blank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      page_q <= '0;
      led_q  <= 1'b0;
      hex_q  <= '1;
    end else begin
      div_q  <= div_d;
      page_q <= page_d;
      led_q  <= led_d;
      hex_q  <= hex_d;
    end
  end

  assign hex_n    = hex_q;
  assign page_idx = page_q;
  assign step_led = led_q;

endmodule

// File: tb/tb_debug_panel.sv
// Directed self-checking bench for debug_panel with a short debounce and run divider.
module tb_debug_panel;

  localparam logic [27:0] HexPage0 = {7'h08, 7'h03, 7'h46, 7'h21};  // A b C d
  localparam logic [27:0] HexPage1 = {7'h79, 7'h24, 7'h30, 7'h19};  // 1 2 3 4
  localparam logic [27:0] HexAlt   = {7'h12, 7'h06, 7'h0E, 7'h40};  // 5 E F 0

  logic        clk = 1'b0;
  logic        rst;
  logic        key_step_n, key_page_n, sw_run;
  logic [31:0] debug_value;
  logic        cpu_step;
  logic [27:0] hex_n;
  logic [0:0]  page_idx;
  logic        step_led;

  int unsigned cyc = 0;
  int unsigned pulses[$];
  int          n_checks = 0;
  int          n_fail = 0;

  debug_panel #(
    .DATA_W      (32),
    .NUM_DIGITS  (4),
    .DEBOUNCE_CYC(4),
    .RUN_DIV     (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_step_n (key_step_n),
    .key_page_n (key_page_n),
    .sw_run     (sw_run),
    .debug_value(debug_value),
    .cpu_step   (cpu_step),
    .hex_n      (hex_n),
    .page_idx   (page_idx),
    .step_led   (step_led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the posedge count of every cycle in which cpu_step is high.
  always @(negedge clk) begin
    if (cpu_step) pulses.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_pulse(input string tag, input int unsigned idx, input int unsigned exp);
    if (pulses.size() > idx) check_eq(tag, 64'(pulses[idx]), 64'(exp));
    else check_eq(tag, 64'hDEAD, 64'(exp));
  endtask

  initial begin
    int unsigned base, t0, t_last, t_r;
    logic [5:0]  bounce_seq;

    rst         = 1'b0;
    key_step_n  = 1'b1;
    key_page_n  = 1'b1;
    sw_run      = 1'b0;
    debug_value = 32'h1234_ABCD;
    #2 rst = 1'b1;
    tick(3);
    check_eq("rst_step", 64'(cpu_step), 64'd0);
    check_eq("rst_led", 64'(step_led), 64'd0);
    check_eq("rst_page", 64'(page_idx), 64'd0);
    check_eq("rst_hex", 64'(hex_n), 64'hFFF_FFFF);
    rst = 1'b0;
    tick(1);
    check_eq("hex_after_rst", 64'(hex_n), 64'(HexPage0));

    // Clean press held 20 cycles in manual mode.
    tick(2);
    base = pulses.size();
    key_step_n = 1'b0;
    t0 = cyc;
    tick(20);
    key_step_n = 1'b1;
    tick(12);
    check_eq("clean_count", 64'(pulses.size() - base), 64'd1);
    check_pulse("clean_latency", base, t0 + 8);
    check_eq("clean_led", 64'(step_led), 64'd1);

    // Bounce low-high-low-low-high, then held low.
    base = pulses.size();
    bounce_seq = 6'b010010;
    t_last = 0;
    for (int i = 0; i < 6; i++) begin
      key_step_n = bounce_seq[i];
      if (i == 5) t_last = cyc;
      tick(1);
    end
    tick(19);
    key_step_n = 1'b1;
    tick(12);
    check_eq("bounce_count", 64'(pulses.size() - base), 64'd1);
    check_pulse("bounce_latency", base, t_last + 8);
    check_eq("bounce_led", 64'(step_led), 64'd0);

    // Free-run mode with a step-key press that must be ignored.
    base = pulses.size();
    sw_run = 1'b1;
    t_r = cyc;
    tick(5);
    key_step_n = 1'b0;
    tick(10);
    key_step_n = 1'b1;
    tick(9);
    sw_run = 1'b0;
    tick(12);
    check_eq("run_count", 64'(pulses.size() - base), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check_pulse($sformatf("run_pulse%0d", k), base + k, t_r + 7 + 5 * k);
    end
    check_eq("run_led", 64'(step_led), 64'd0);

    // Page advance.
    key_page_n = 1'b0;
    tick(10);
    key_page_n = 1'b1;
    tick(12);
    check_eq("page1_idx", 64'(page_idx), 64'd1);
    check_eq("page1_hex", 64'(hex_n), 64'(HexPage1));

    // Page and step keys together: page wraps and one step pulse.
    base = pulses.size();
    key_page_n = 1'b0;
    key_step_n = 1'b0;
    tick(10);
    key_page_n = 1'b1;
    key_step_n = 1'b1;
    tick(12);
    check_eq("wrap_idx", 64'(page_idx), 64'd0);
    check_eq("wrap_hex", 64'(hex_n), 64'(HexPage0));
    check_eq("both_step_count", 64'(pulses.size() - base), 64'd1);
    check_eq("both_led", 64'(step_led), 64'd1);

    // One-cycle latency from debug_value to hex_n.
    debug_value = 32'h9876_5EF0;
    tick(1);
    check_eq("value_hex", 64'(hex_n), 64'(HexAlt));

    // Reset two cycles before a pending accept, key kept held across reset.
    tick(2);
    base = pulses.size();
    key_step_n = 1'b0;
    tick(6);
    rst = 1'b1;
    #1;
    check_eq("midrst_nopulse", 64'(pulses.size() - base), 64'd0);
    check_eq("midrst_step", 64'(cpu_step), 64'd0);
    check_eq("midrst_led", 64'(step_led), 64'd0);
    check_eq("midrst_page", 64'(page_idx), 64'd0);
    check_eq("midrst_hex", 64'(hex_n), 64'hFFF_FFFF);
    tick(2);
    rst = 1'b0;
    t0 = cyc;
    tick(15);
    key_step_n = 1'b1;
    tick(12);
    check_eq("postrst_count", 64'(pulses.size() - base), 64'd1);
    check_pulse("postrst_latency", base, t0 + 8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
